bus_gate_arb: RTL and testbench

Arbiter and sequencer that drives the active-low enables of the tristate gates onto the shared LC-3 datapath bus. Each bus source (PC, MARMUX, ALU, MDR, …) requests ownership. The block grants exactly one source at a time and produces its `en_n` directly. It enforces a programmable dead-time of all gates off between owners, so no two drivers ever overlap on the bus.

---
 rtl/bus_gate_arb.sv | 138 +++++++++++++
 tb/tb_bus_gate_arb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_gate_arb.sv
// Round-robin owner arbiter for the shared datapath bus: drives one active-low
// gate enable at a time and inserts TURNAROUND all-off cycles between owners.
module bus_gate_arb #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned OW         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] gnt,
    output logic [N_SRC-1:0] gate_n,
    output logic [OW-1:0]    owner,
    output logic             busy
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_TURN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] gnt_q, gnt_d, gate_n_q;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q;
    logic             any_req;
    logic [OW-1:0]    win;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] x);
        if (x == OW'(N_SRC - 1)) begin
            return '0;
        end
        return x + OW'(1);
    endfunction

    // Round-robin pick: first requester at or after ptr, wrapping.
    always_comb begin
        int unsigned idx;
        any_req = 1'b0;
        win     = '0;
        idx     = 0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (!any_req && req[OW'(idx)]) begin
                any_req = 1'b1;
                win     = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d   = N_SRC'(1) << win;
                    owner_d = win;
                    ptr_d   = wrap_inc(win);
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                // No preemption: ownership ends only when the owner drops req.
                if (!req[owner_q]) begin
                    gnt_d = '0;
                    ptr_d = wrap_inc(owner_q);
                    if (TURNAROUND == 0) begin
                        if (any_req) begin
                            gnt_d   = N_SRC'(1) << win;
                            owner_d = win;
                            ptr_d   = wrap_inc(win);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d   = CW'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);
                        state_d = S_TURN;
                    end
                end
            end
            S_TURN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (any_req) begin
                    gnt_d   = N_SRC'(1) << win;
                    owner_d = win;
                    ptr_d   = wrap_inc(win);
                    state_d = S_OWN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Async reset drops every gate immediately, even mid-grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            gate_n_q <= '1;
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gate_n_q <= ~gnt_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= |gnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign gate_n = gate_n_q;
    assign owner  = owner_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_bus_gate_arb.sv
// Bench for bus_gate_arb: four configurations share clock/reset; a queue-based
// scoreboard fed by an owner/pointer/wait reference model checks every cycle.
module tb_bus_gate_arb;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req4;
    logic [4:0] req5;

    always #5 clk = ~clk;

    logic [3:0] g0, g1, g2, gn0, gn1, gn2;
    logic [1:0] o0, o1, o2;
    logic       b0, b1, b2, b3;
    logic [4:0] g3, gn3;
    logic [2:0] o3;

    bus_gate_arb #(.N_SRC(4), .TURNAROUND(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req4), .gnt(g0), .gate_n(gn0), .owner(o0), .busy(b0));
    bus_gate_arb #(.N_SRC(4), .TURNAROUND(2)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req4), .gnt(g1), .gate_n(gn1), .owner(o1), .busy(b1));
    bus_gate_arb #(.N_SRC(4), .TURNAROUND(0)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req4), .gnt(g2), .gate_n(gn2), .owner(o2), .busy(b2));
    bus_gate_arb #(.N_SRC(5), .TURNAROUND(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req5), .gnt(g3), .gate_n(gn3), .owner(o3), .busy(b3));

    logic [15:0] d_gnt  [NI];
    logic [15:0] d_gate [NI];
    logic [3:0]  d_own  [NI];
    logic        d_busy [NI];

    always_comb begin
        d_gnt[0] = 16'(g0); d_gate[0] = 16'(gn0); d_own[0] = 4'(o0); d_busy[0] = b0;
        d_gnt[1] = 16'(g1); d_gate[1] = 16'(gn1); d_own[1] = 4'(o1); d_busy[1] = b1;
        d_gnt[2] = 16'(g2); d_gate[2] = 16'(gn2); d_own[2] = 4'(o2); d_busy[2] = b2;
        d_gnt[3] = 16'(g3); d_gate[3] = 16'(gn3); d_own[3] = 4'(o3); d_busy[3] = b3;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ns(input int k);
        return (k == 3) ? 5 : 4;
    endfunction

    function automatic int ta(input int k);
        case (k)
            0: return 1;
            1: return 2;
            2: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [15:0] mask(input int k);
        return 16'((32'd1 << ns(k)) - 1);
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [NI-1:0][15:0] gnt;
        logic [NI-1:0][3:0]  own;
    } exp_t;

    exp_t sb_q[$];
    bit   m_has  [NI];
    int   m_own  [NI];
    int   m_ptr  [NI];
    int   m_wait [NI];

    function automatic logic [15:0] req_of(input int k);
        return (k == 3) ? 16'(req5) : 16'(req4);
    endfunction

    task automatic try_grant(input int k, input logic [15:0] r);
        for (int i = 0; i < ns(k); i++) begin
            int idx;
            idx = (m_ptr[k] + i) % ns(k);
            if (r[idx]) begin
                m_has[k] = 1'b1;
                m_own[k] = idx;
                m_ptr[k] = (idx + 1) % ns(k);
                return;
            end
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            e.gnt[k] = m_has[k] ? (16'd1 << m_own[k]) : 16'd0;
            e.own[k] = 4'(m_own[k]);
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [15:0] r;
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                m_has[k] = 1'b0; m_own[k] = 0; m_ptr[k] = 0; m_wait[k] = 0;
            end
            sb_q.delete();
        end else begin
            for (int k = 0; k < NI; k++) begin
                r = req_of(k);
                if (m_has[k]) begin
                    if (!r[m_own[k]]) begin
                        m_has[k] = 1'b0;
                        m_ptr[k] = (m_own[k] + 1) % ns(k);
                        if (ta(k) == 0) try_grant(k, r);
                        else m_wait[k] = ta(k);
                    end
                end else if (m_wait[k] > 0) begin
                    m_wait[k]--;
                    if (m_wait[k] == 0) try_grant(k, r);
                end else begin
                    try_grant(k, r);
                end
            end
        end
        sb_q.push_back(snapshot());
    end

    // ---------------- monitor ----------------
    bit          mon_armed = 1'b0;
    bit          rr_on = 1'b0;
    int          rr_log[$];
    logic [15:0] rr_prev = '0;
    logic [3:0]  rr_prev_own = '0;
    int          dead [NI] = '{0, 0, 0, 0};
    int          last [NI] = '{-1, -1, -1, -1};

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() == 0) begin
            if (mon_armed) chk(1'b0, "sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            mon_armed = 1'b1;
            for (int k = 0; k < NI; k++) begin
                chk(d_gnt[k] == e.gnt[k] && d_own[k] == e.own[k] && d_busy[k] == (e.gnt[k] != 16'd0),
                    $sformatf("sb_u%0d gnt/owner/busy", k),
                    {d_gnt[k], 8'(d_own[k]), 8'(d_busy[k])},
                    {e.gnt[k], 8'(e.own[k]), 8'(e.gnt[k] != 16'd0)});
            end
        end
        for (int k = 0; k < NI; k++) begin
            chk((d_gnt[k] & (d_gnt[k] - 16'd1)) == 16'd0, $sformatf("onehot_u%0d", k),
                32'(d_gnt[k]), 32'(d_gnt[k] & (d_gnt[k] - 16'd1) ^ d_gnt[k]));
            chk(d_gate[k] == (~d_gnt[k] & mask(k)), $sformatf("gate_n_u%0d", k),
                32'(d_gate[k]), 32'(~d_gnt[k] & mask(k)));
            chk(d_busy[k] == (d_gnt[k] != 16'd0), $sformatf("busy_u%0d", k),
                32'(d_busy[k]), 32'(d_gnt[k] != 16'd0));
            if (d_gnt[k] == 16'd0) begin
                dead[k]++;
            end else begin
                if (last[k] >= 0 && int'(d_own[k]) != last[k])
                    chk(dead[k] >= ta(k), $sformatf("deadtime_u%0d", k), 32'(dead[k]), 32'(ta(k)));
                last[k] = int'(d_own[k]);
                dead[k] = 0;
            end
        end
        if (rr_on && d_gnt[0] != 16'd0 && (rr_prev == 16'd0 || d_own[0] != rr_prev_own))
            rr_log.push_back(int'(d_own[0]));
        rr_prev     = d_gnt[0];
        rr_prev_own = d_own[0];
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [3:0] r4, input logic [4:0] r5);
        req4 = r4;
        req5 = r5;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_rr [5];
        int rst_left;
        logic [3:0] r4;
        logic [4:0] r5;
        exp_rr = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        req4  = '0;
        req5  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(d_gnt[0] == 16'd0 && d_gate[0] == 16'hF && d_busy[0] == 1'b0 && d_own[0] == 4'd0,
            "reset_values_u0", {d_gnt[0], d_gate[0]}, {16'd0, 16'hF});
        rst_n = 1'b1;

        // single owner, T=1
        cyc(4'b0100, 5'b0);
        chk(d_gnt[0] == 16'b0100, "single_gnt", 32'(d_gnt[0]), 32'b0100);
        chk(d_gate[0] == 16'b1011, "single_gate_n", 32'(d_gate[0]), 32'b1011);
        chk(d_own[0] == 4'd2, "single_owner", 32'(d_own[0]), 32'd2);
        repeat (4) cyc(4'b0100, 5'b0);
        chk(d_gnt[0] == 16'b0100, "single_hold", 32'(d_gnt[0]), 32'b0100);
        cyc(4'b0000, 5'b0);
        chk(d_gnt[0] == 16'd0 && d_busy[0] == 1'b0, "single_release", 32'(d_gnt[0]), 32'd0);
        repeat (3) cyc(4'b0000, 5'b0);

        // turnaround, T=2
        cyc(4'b0011, 5'b0);
        chk(d_gnt[1] == 16'b0001, "turn_first_owner", 32'(d_gnt[1]), 32'b0001);
        cyc(4'b0011, 5'b0);
        cyc(4'b0010, 5'b0);
        chk(d_gate[1] == 16'hF, "turn_dead1", 32'(d_gate[1]), 32'hF);
        cyc(4'b0010, 5'b0);
        chk(d_gate[1] == 16'hF, "turn_dead2", 32'(d_gate[1]), 32'hF);
        cyc(4'b0010, 5'b0);
        chk(d_gnt[1] == 16'b0010, "turn_next_owner", 32'(d_gnt[1]), 32'b0010);
        repeat (4) cyc(4'b0000, 5'b0);

        // asynchronous reset while source 2 owns the bus
        cyc(4'b0100, 5'b0);
        chk(d_gnt[0] == 16'b0100, "pre_reset_gnt", 32'(d_gnt[0]), 32'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk(d_gate[0] == 16'hF, "async_reset_gate_n", 32'(d_gate[0]), 32'hF);
        chk(d_gnt[0] == 16'd0 && d_busy[0] == 1'b0, "async_reset_gnt_busy",
            {d_gnt[0], 16'(d_busy[0])}, 32'd0);
        chk(d_own[0] == 4'd0, "async_reset_owner", 32'(d_own[0]), 32'd0);
        repeat (2) cyc(4'b0000, 5'b0);
        rst_n = 1'b1;

        // round-robin, T=1: each owner holds two cycles then drops for one
        rr_on = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(4'b1111, 5'b0);
            cyc(4'b1111, 5'b0);
            cyc(4'b1111 & ~(4'b0001 << (k % 4)), 5'b0);
        end
        rr_on = 1'b0;
        chk(rr_log.size() == 5, "rr_count", 32'(rr_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < rr_log.size(); i++)
            chk(rr_log[i] == exp_rr[i], $sformatf("rr_order[%0d]", i), 32'(rr_log[i]), 32'(exp_rr[i]));
        repeat (5) cyc(4'b0000, 5'b0);

        // zero turnaround handoff
        cyc(4'b0010, 5'b0);
        cyc(4'b1010, 5'b0);
        chk(d_gnt[2] == 16'b0010, "zt_before", 32'(d_gnt[2]), 32'b0010);
        cyc(4'b1000, 5'b0);
        chk(d_gnt[2] == 16'b1000, "zt_handoff", 32'(d_gnt[2]), 32'b1000);
        repeat (5) cyc(4'b0000, 5'b0);

        // random soak with reset pulses
        rst_left = 0;
        r4 = '0;
        r5 = '0;
        for (int c = 0; c < 10000; c++) begin
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                rst_left = int'($urandom_range(4, 6));
            end
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) r4[b] = ~r4[b];
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 5) == 0) r5[b] = ~r5[b];
            cyc(r4, r5);
        end
        rst_n = 1'b1;
        repeat (8) cyc(4'b0000, 5'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
